// File: rtl/stat_pkt_tx.sv
// Camera stat snapshot packetiser: waits for a frame boundary (or a timeout), captures all stat
// outputs coherently and streams them as a 20-byte checksummed packet over a valid/ready byte link.
module stat_pkt_tx #(
  parameter int CNTR_W      = 32,
  parameter int TIMEOUT_CYC = 24000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic [7:0]        frm_per_sec,
  input  logic [CNTR_W-1:0] total_frm,
  input  logic [CNTR_W-1:0] total_byte,
  input  logic [10:0]       lines_per_frm,
  input  logic [11:0]       bytes_per_line,
  input  logic [18:0]       bytes_per_frm,
  input  logic              frm_lt_512k_err,
  input  logic              snap_req,
  output logic              busy,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, SEND} state_t;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

  state_t       state;
  logic         vsync_d1;
  logic         vsync_fe;
  logic [31:0]  to_ctr;
  logic         stale;
  logic [7:0]   err_cnt;
  logic [4:0]   idx;
  logic [4:0]   nxt_idx;
  logic [7:0]   nxt_byte;
  logic [7:0]   csum;
  logic [151:0] body;

  logic [7:0]   sh_fps;
  logic [31:0]  sh_frm;
  logic [31:0]  sh_byte;
  logic [10:0]  sh_lpf;
  logic [11:0]  sh_bpl;
  logic [18:0]  sh_bpf;
  logic [7:0]   sh_err;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
    return (inc && (v != 8'hFF)) ? v + 8'd1 : v;
  endfunction

  assign vsync_fe = vsync_d1 & ~vsync;
  assign busy     = (state != IDLE);

  // Packet bytes 0..18, MSB-first; byte 19 is the running XOR of these.
  assign body = {8'hA5, 6'b0, stale, (sh_err != 8'd0), sh_fps, sh_frm, sh_byte,
                 5'b0, sh_lpf, 4'b0, sh_bpl, 5'b0, sh_bpf, sh_err};

  always_comb begin
    csum = 8'h00;
    for (int k = 0; k < 19; k++) csum = csum ^ body[8*k +: 8];
  end

  assign nxt_idx = idx + 5'd1;

  always_comb begin
    nxt_byte = csum;
    for (int k = 0; k < 19; k++)
      if (nxt_idx == 5'(k)) nxt_byte = body[8*(18-k) +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      vsync_d1 <= 1'b0;
      to_ctr   <= '0;
      stale    <= 1'b0;
      err_cnt  <= '0;
      idx      <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      vsync_d1 <= vsync;
      // The capture cycle hands the pending count (plus any same-cycle pulse) to the shadow.
      if (state == CAPTURE) err_cnt <= '0;
      else                  err_cnt <= sat_inc(err_cnt, frm_lt_512k_err);
      case (state)
        IDLE: begin
          if (snap_req) begin
            state  <= WAIT_VS;
            to_ctr <= '0;
          end
        end
        WAIT_VS: begin
          if (vsync_fe) begin
            state <= CAPTURE;
            stale <= 1'b0;
          end else if (to_ctr == TO_LAST) begin
            state <= CAPTURE;
            stale <= 1'b1;
          end else begin
            to_ctr <= to_ctr + 32'd1;
          end
        end
        CAPTURE: begin
          state    <= SEND;
          idx      <= '0;
          tx_valid <= 1'b1;
          tx_data  <= 8'hA5;
        end
        SEND: begin
          if (tx_ready) begin
            if (idx == 5'd19) begin
              state    <= IDLE;
              tx_valid <= 1'b0;
            end else begin
              idx     <= nxt_idx;
              tx_data <= nxt_byte;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == CAPTURE) begin
      sh_fps  <= frm_per_sec;
      sh_frm  <= 32'(total_frm);
      sh_byte <= 32'(total_byte);
      sh_lpf  <= lines_per_frm;
      sh_bpl  <= bytes_per_line;
      sh_bpf  <= bytes_per_frm;
      sh_err  <= sat_inc(err_cnt, frm_lt_512k_err);
    end
  end

endmodule

// File: tb/tb_stat_pkt_tx.sv
// Bench for stat_pkt_tx: table of snapshot scenarios plus randomized snapshots, each packet
// compared byte-for-byte against a packet assembled from the field values the bench applied.
module tb_stat_pkt_tx;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vsync;
  logic [7:0]  frm_per_sec;
  logic [31:0] total_frm, total_byte;
  logic [10:0] lines_per_frm;
  logic [11:0] bytes_per_line;
  logic [18:0] bytes_per_frm;
  logic        frm_lt_512k_err, snap_req;
  logic        busy, tx_valid, tx_ready;
  logic [7:0]  tx_data;

  stat_pkt_tx #(.CNTR_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .frm_per_sec(frm_per_sec),
    .total_frm(total_frm), .total_byte(total_byte), .lines_per_frm(lines_per_frm),
    .bytes_per_line(bytes_per_line), .bytes_per_frm(bytes_per_frm),
    .frm_lt_512k_err(frm_lt_512k_err), .snap_req(snap_req), .busy(busy),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  fps;
    logic [31:0] frm;
    logic [31:0] byt;
    logic [10:0] lpf;
    logic [11:0] bpl;
    logic [18:0] bpf;
    int          idle_pulses;
    int          npre;
    bit          cap_pulse;
    int          vs_at;      // cycle after snap in which vsync is first low; -1 = never
    bit          rmode;      // 0: always ready, 1: random ready plus a 50-cycle stall at byte 7
    bit          has_exp;
    logic [7:0]  exp_b1;
    logic [7:0]  exp_b18;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          err_acc = 0;
  bit          rnd_pulses = 0;
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_pkt[20];
  bit          prev_stall = 0;
  logic [7:0]  prev_data = '0;
  vec_t        tbl[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic int sat8(input int a);
    return (a > 255) ? 255 : a;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic build_exp(input vec_t v, input bit st, input int err);
    logic [7:0] x;
    exp_pkt[0]  = 8'hA5;
    exp_pkt[1]  = {6'b0, st, (err != 0)};
    exp_pkt[2]  = v.fps;
    exp_pkt[3]  = v.frm[31:24]; exp_pkt[4]  = v.frm[23:16];
    exp_pkt[5]  = v.frm[15:8];  exp_pkt[6]  = v.frm[7:0];
    exp_pkt[7]  = v.byt[31:24]; exp_pkt[8]  = v.byt[23:16];
    exp_pkt[9]  = v.byt[15:8];  exp_pkt[10] = v.byt[7:0];
    exp_pkt[11] = 8'(v.lpf >> 8); exp_pkt[12] = v.lpf[7:0];
    exp_pkt[13] = 8'(v.bpl >> 8); exp_pkt[14] = v.bpl[7:0];
    exp_pkt[15] = 8'(v.bpf >> 16); exp_pkt[16] = v.bpf[15:8]; exp_pkt[17] = v.bpf[7:0];
    exp_pkt[18] = 8'(err);
    x = 8'h00;
    for (int i = 0; i < 19; i++) x = x ^ exp_pkt[i];
    exp_pkt[19] = x;
  endtask

  // Byte collector and stall-stability watcher.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && tx_valid) chk("stall_hold", {24'h0, tx_data}, {24'h0, prev_data});
      if (tx_valid && tx_ready) rx_q.push_back(tx_data);
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic apply_fields(input vec_t v);
    frm_per_sec = v.fps; total_frm = v.frm; total_byte = v.byt;
    lines_per_frm = v.lpf; bytes_per_line = v.bpl; bytes_per_frm = v.bpf;
  endtask

  task automatic do_snap(input vec_t v, input string tag);
    int cc, exp_err, n, stall_left;
    bit stalled;
    rx_q.delete();
    apply_fields(v);
    for (int p = 0; p < v.idle_pulses; p++) begin
      frm_lt_512k_err = 1'b1; tick; err_acc = sat8(err_acc + 1);
      frm_lt_512k_err = 1'b0; tick;
    end
    snap_req = 1'b1; tick; snap_req = 1'b0;
    chk({tag, "_busy_wait"}, busy, 1);
    cc = (v.vs_at >= 0) ? v.vs_at + 1 : TO;
    for (int cyc = 0; cyc < cc; cyc++) begin
      vsync = (v.vs_at >= 0 && cyc >= v.vs_at) ? 1'b0 : 1'b1;
      snap_req = (cyc == 2);
      frm_lt_512k_err = ((cyc % 2) == 1) && (cyc < 2 * v.npre);
      if (frm_lt_512k_err) err_acc = sat8(err_acc + 1);
      tick;
    end
    snap_req = 1'b0;
    frm_lt_512k_err = v.cap_pulse;
    exp_err = sat8(err_acc + int'(v.cap_pulse));
    err_acc = 0;
    chk({tag, "_valid_in_capture"}, tx_valid, 0);
    tick;
    frm_lt_512k_err = 1'b0;
    chk({tag, "_b0_latency"}, {tx_valid, tx_data}, {1'b1, 8'hA5});
    build_exp(v, (v.vs_at < 0), exp_err);
    n = 0; stalled = 0; stall_left = 0;
    while (!(rx_q.size() >= 20 && !busy) && n < 600) begin
      if (!v.rmode) tx_ready = 1'b1;
      else begin
        if (rx_q.size() == 7 && !stalled) begin stalled = 1; stall_left = 50; end
        if (stall_left > 0) begin tx_ready = 1'b0; stall_left--; end
        else tx_ready = 1'($urandom_range(0, 1));
      end
      frm_per_sec = 8'($urandom); total_frm = $urandom; total_byte = $urandom;
      lines_per_frm = 11'($urandom); bytes_per_line = 12'($urandom); bytes_per_frm = 19'($urandom);
      snap_req = (rx_q.size() < 15) && ($urandom_range(0, 9) == 0);
      frm_lt_512k_err = rnd_pulses && ($urandom_range(0, 7) == 0);
      if (frm_lt_512k_err) err_acc = sat8(err_acc + 1);
      tick; n++;
    end
    snap_req = 1'b0; frm_lt_512k_err = 1'b0; tx_ready = 1'b0; vsync = 1'b1;
    chk({tag, "_done_in_budget"}, (n < 600), 1);
    tick; tick; tick;
    chk({tag, "_nbytes"}, rx_q.size(), 20);
    chk({tag, "_idle_after"}, {busy, tx_valid}, 2'b00);
    if (rx_q.size() == 20) begin
      for (int i = 0; i < 20; i++)
        chk($sformatf("%s_B%0d", tag, i), {24'h0, rx_q[i]}, {24'h0, exp_pkt[i]});
      if (v.has_exp) begin
        chk({tag, "_B1_tbl"}, {24'h0, rx_q[1]}, {24'h0, v.exp_b1});
        chk({tag, "_B18_tbl"}, {24'h0, rx_q[18]}, {24'h0, v.exp_b18});
      end
    end
  endtask

  initial begin
    vec_t v;
    int n;
    tbl[0] = '{8'd30, 32'h12345678, 32'h9ABCDEF0, 11'd480, 12'd1280, 19'd512000,
               0, 0, 1'b0, 5, 1'b0, 1'b1, 8'h00, 8'h00};
    tbl[1] = '{8'd15, 32'hCAFEF00D, 32'h00000102, 11'd720, 12'd2047, 19'd409600,
               0, 0, 1'b0, -1, 1'b0, 1'b1, 8'h02, 8'h00};
    tbl[2] = '{8'd60, 32'h00000001, 32'hFFFFFFFF, 11'd2047, 12'd4095, 19'd524287,
               0, 0, 1'b0, 99, 1'b0, 1'b1, 8'h00, 8'h00};
    tbl[3] = '{8'd25, 32'h0BADBEEF, 32'h13579BDF, 11'd1080, 12'd3840, 19'd100000,
               0, 3, 1'b1, 10, 1'b1, 1'b1, 8'h01, 8'h04};
    tbl[4] = '{8'd24, 32'h00ABCDEF, 32'h76543210, 11'd600, 12'd800, 19'd480000,
               0, 0, 1'b0, 7, 1'b0, 1'b1, 8'h00, 8'h00};
    tbl[5] = '{8'd10, 32'h80000000, 32'h00000000, 11'd1, 12'd1, 19'd1,
               300, 0, 1'b0, 6, 1'b1, 1'b1, 8'h01, 8'hFF};

    rst_n = 1'b0; vsync = 1'b1; snap_req = 1'b0; frm_lt_512k_err = 1'b0; tx_ready = 1'b0;
    frm_per_sec = '0; total_frm = '0; total_byte = '0;
    lines_per_frm = '0; bytes_per_line = '0; bytes_per_frm = '0;
    tick; tick; tick;
    chk("reset_outputs", {busy, tx_valid, tx_data}, 10'h000);
    rst_n = 1'b1;
    tick; tick;
    chk("idle_after_release", {busy, tx_valid}, 2'b00);

    for (int t = 0; t < 6; t++) do_snap(tbl[t], $sformatf("tbl%0d", t));

    rnd_pulses = 1;
    for (int r = 0; r < 8; r++) begin
      v.fps = 8'($urandom); v.frm = $urandom; v.byt = $urandom;
      v.lpf = 11'($urandom); v.bpl = 12'($urandom); v.bpf = 19'($urandom);
      v.idle_pulses = $urandom_range(0, 5);
      v.npre = $urandom_range(0, 3);
      v.cap_pulse = 1'($urandom_range(0, 1));
      v.vs_at = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(8, 90));
      v.rmode = 1'b1; v.has_exp = 1'b0; v.exp_b1 = '0; v.exp_b18 = '0;
      do_snap(v, $sformatf("rnd%0d", r));
    end
    rnd_pulses = 0;

    // Asynchronous reset in the middle of a packet, then a clean packet afterwards.
    rx_q.delete();
    apply_fields(tbl[0]);
    snap_req = 1'b1; tick; snap_req = 1'b0;
    tick; tick; vsync = 1'b0; tick; vsync = 1'b1;
    tx_ready = 1'b1;
    n = 0;
    while (rx_q.size() < 7 && n < 100) begin tick; n++; end
    chk("rst_reach_b7", (n < 100), 1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {busy, tx_valid, tx_data}, 10'h000);
    tick; tick;
    tx_ready = 1'b0;
    rst_n = 1'b1;
    err_acc = 0;
    tick; tick;
    do_snap(tbl[0], "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
